// File: rtl/motor_ramp_sequencer.sv
// Motor speed ramp sequencer: slews motor_speed toward commanded targets, brakes and waits a dead time on reversal.
// Optional command watchdog is compiled in when MOTOR_RAMP_WATCHDOG_EN is defined.
module motor_ramp_sequencer #(
  parameter int COUNTER_WIDTH = 16,
  parameter int TICK_CYCLES   = 50000,
  parameter int RAMP_STEP     = 256,
  parameter int DEAD_CYCLES   = 1000,
  parameter int WDOG_TICKS    = 500
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_dir,
  input  logic [COUNTER_WIDTH-1:0] cmd_speed,
  output logic                     motor_dir,
  output logic [COUNTER_WIDTH-1:0] motor_speed,
  output logic                     busy,
  output logic                     at_speed,
  output logic                     wdog_trip
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] STEP = COUNTER_WIDTH'(RAMP_STEP);

  typedef enum logic [2:0] {IDLE, RAMP, HOLD, BRAKE, DEAD} state_t;

  state_t                   state, state_nxt;
  logic [PW-1:0]            presc;
  logic                     tick;
  logic [DW-1:0]            dead_cnt, dead_cnt_nxt;
  logic [COUNTER_WIDTH-1:0] speed_nxt, tgt_speed, tgt_speed_nxt;
  logic                     dir_nxt, tgt_dir, tgt_dir_nxt;
  logic                     accept, reversal, wdog_fire;

  // Saturating move of cur toward goal by at most STEP; lands exactly on goal, never past it.
  function automatic logic [COUNTER_WIDTH-1:0] step_toward(
    input logic [COUNTER_WIDTH-1:0] cur,
    input logic [COUNTER_WIDTH-1:0] goal
  );
    if (cur < goal)
      return (goal - cur > STEP) ? cur + STEP : goal;
    else
      return (cur - goal > STEP) ? cur - STEP : goal;
  endfunction

  assign cmd_ready = (state != DEAD);
  assign accept    = cmd_valid && cmd_ready;
  assign reversal  = accept && (cmd_dir != motor_dir) && (motor_speed != '0);
  assign tick      = (presc == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) presc <= '0;
    else             presc <= presc + 1'b1;
  end

`ifdef MOTOR_RAMP_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_TICKS + 1);
  localparam logic [WW-1:0] WDOG_LIMIT = WW'(WDOG_TICKS);

  logic [WW-1:0] wdog_cnt;
  logic          wdog_trip_q;

  // Fires once per silence period; the sticky flag keeps it from re-arming until a command arrives.
  assign wdog_fire = (wdog_cnt == WDOG_LIMIT) && (state != IDLE) && !wdog_trip_q && !accept;
  assign wdog_trip = wdog_trip_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt    <= '0;
      wdog_trip_q <= 1'b0;
    end else if (accept) begin
      wdog_cnt    <= '0;
      wdog_trip_q <= 1'b0;
    end else begin
      if (tick && wdog_cnt != WDOG_LIMIT) wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_fire) wdog_trip_q <= 1'b1;
    end
  end
`else
  assign wdog_fire = 1'b0;
  assign wdog_trip = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    speed_nxt     = motor_speed;
    dir_nxt       = motor_dir;
    tgt_speed_nxt = tgt_speed;
    tgt_dir_nxt   = tgt_dir;
    dead_cnt_nxt  = '0;
    busy          = 1'b0;
    at_speed      = 1'b0;

    if (accept) begin
      tgt_speed_nxt = cmd_speed;
      tgt_dir_nxt   = cmd_dir;
    end else if (wdog_fire) begin
      tgt_speed_nxt = '0;
    end

    case (state)
      IDLE: begin
        if (accept && cmd_speed != '0) begin
          dir_nxt   = cmd_dir;
          state_nxt = RAMP;
        end
      end
      RAMP: begin
        busy = 1'b1;
        // Steps always use the target held before this edge.
        if (tick) speed_nxt = step_toward(motor_speed, tgt_speed);
        if (reversal) begin
          state_nxt = BRAKE;
        end else if (accept && cmd_dir != motor_dir) begin
          dir_nxt   = cmd_dir;
          speed_nxt = motor_speed;
        end else if (!accept && !wdog_fire && motor_speed == tgt_speed) begin
          state_nxt = (tgt_speed != '0) ? HOLD : IDLE;
        end
      end
      HOLD: begin
        at_speed = 1'b1;
        if (reversal)                                  state_nxt = BRAKE;
        else if (accept && cmd_speed != motor_speed)   state_nxt = RAMP;
        else if (wdog_fire)                            state_nxt = RAMP;
      end
      BRAKE: begin
        busy = 1'b1;
        if (tick) speed_nxt = step_toward(motor_speed, '0);
        if (motor_speed == '0) state_nxt = DEAD;
      end
      DEAD: begin
        busy = 1'b1;
        if (dead_cnt == DEAD_LAST) begin
          dir_nxt   = tgt_dir;
          state_nxt = (tgt_speed != '0) ? RAMP : IDLE;
        end else begin
          dead_cnt_nxt = dead_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      motor_speed <= '0;
      motor_dir   <= 1'b0;
      tgt_speed   <= '0;
      tgt_dir     <= 1'b0;
      dead_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      motor_speed <= speed_nxt;
      motor_dir   <= dir_nxt;
      tgt_speed   <= tgt_speed_nxt;
      tgt_dir     <= tgt_dir_nxt;
      dead_cnt    <= dead_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed scenarios plus randomized commands for motor_ramp_sequencer, checked cycle by cycle
// against a behavioural model of the ramp/brake/dead-time rules.
module tb_motor_ramp_sequencer;
  localparam int CW   = 16;
  localparam int TICK = 4;
  localparam int STEP = 256;
  localparam int DEAD = 6;
  localparam int WDOG = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_speed = '0;
  logic          cmd_ready, motor_dir, busy, at_speed, wdog_trip;
  logic [CW-1:0] motor_speed;

  int checks = 0;
  int failures = 0;

  motor_ramp_sequencer #(
    .COUNTER_WIDTH(CW), .TICK_CYCLES(TICK), .RAMP_STEP(STEP),
    .DEAD_CYCLES(DEAD), .WDOG_TICKS(WDOG)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_speed(cmd_speed), .motor_dir(motor_dir),
    .motor_speed(motor_speed), .busy(busy), .at_speed(at_speed), .wdog_trip(wdog_trip)
  );

  always #5 clk = ~clk;

  // Model: speed/direction, latched target, and what the motor is doing (moving, holding, braking, waiting).
  int   m_speed, m_tgt, m_dead_left, m_wd, m_cyc;
  logic m_dir, m_tdir;
  bit   m_move, m_hold, m_brake, m_trip;

  int   prev_speed;
  logic prev_dir;
  int   seq[$];
  int   exp_seq[$];
  int   dut_acc, ready_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int approach(input int cur, input int goal);
    int d;
    d = goal - cur;
    if (d > STEP) d = STEP;
    else if (d < -STEP) d = -STEP;
    return cur + d;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".speed"},     32'(motor_speed), 32'(m_speed));
    chk({tag, ".dir"},       32'(motor_dir),   32'(m_dir));
    chk({tag, ".ready"},     32'(cmd_ready),   32'(m_dead_left == 0));
    chk({tag, ".busy"},      32'(busy),        32'(m_move || m_brake || m_dead_left > 0));
    chk({tag, ".at_speed"},  32'(at_speed),    32'(m_hold));
    chk({tag, ".wdog_trip"}, 32'(wdog_trip),   32'(m_trip));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    m_speed = 0; m_tgt = 0; m_dead_left = 0; m_wd = 0; m_cyc = 0;
    m_dir = 1'b0; m_tdir = 1'b0;
    m_move = 0; m_hold = 0; m_brake = 0; m_trip = 0;
    check_outputs("reset");
    prev_speed = 0;
    prev_dir = 1'b0;
    rst = 1'b0;
  endtask

  task automatic step(input logic v, input logic d, input int s);
    bit   idle, ready, acc, tick, fire, settled;
    int   old_tgt;
    logic old_tdir;
    cmd_valid = v;
    cmd_dir   = d;
    cmd_speed = CW'(s);
    if (v && cmd_ready === 1'b1) dut_acc++;
    if (v && cmd_ready === 1'b0) ready_low++;
    ready = (m_dead_left == 0);
    idle  = ready && !(m_move || m_hold || m_brake);
    acc   = v && ready;
    tick  = (m_cyc % TICK) == TICK - 1;
    m_cyc++;
    fire  = 0;
`ifdef MOTOR_RAMP_WATCHDOG_EN
    fire = (m_wd == WDOG) && !idle && !m_trip && !acc;
    if (acc) begin
      m_wd = 0; m_trip = 0;
    end else begin
      if (tick && m_wd < WDOG) m_wd++;
      if (fire) m_trip = 1;
    end
`endif
    old_tgt  = m_tgt;
    old_tdir = m_tdir;
    if (acc) begin m_tgt = s; m_tdir = d; end
    else if (fire) m_tgt = 0;

    if (idle) begin
      if (acc && s > 0) begin m_dir = d; m_move = 1; end
    end else if (m_move) begin
      if (acc && d != m_dir && m_speed > 0) begin
        if (tick) m_speed = approach(m_speed, old_tgt);
        m_move = 0; m_brake = 1;
      end else if (acc && d != m_dir) begin
        m_dir = d;
      end else begin
        settled = (m_speed == old_tgt);
        if (tick) m_speed = approach(m_speed, old_tgt);
        if (!acc && !fire && settled) begin m_move = 0; m_hold = (old_tgt > 0); end
      end
    end else if (m_hold) begin
      if (acc && d != m_dir) begin m_hold = 0; m_brake = 1; end
      else if ((acc && s != m_speed) || fire) begin m_hold = 0; m_move = 1; end
    end else if (m_brake) begin
      if (m_speed == 0) begin m_brake = 0; m_dead_left = DEAD; end
      else if (tick) m_speed = (m_speed > STEP) ? m_speed - STEP : 0;
    end else begin
      m_dead_left--;
      if (m_dead_left == 0) begin m_dir = old_tdir; m_move = (old_tgt > 0); end
    end

    @(posedge clk);
    #1;
    check_outputs("cycle");
    if (motor_dir !== prev_dir)
      chk("dir_change_at_zero", 32'(prev_speed == 0 && motor_speed == 0), 32'd1);
    if (int'(motor_speed) != prev_speed) seq.push_back(int'(motor_speed));
    prev_speed = int'(motor_speed);
    prev_dir   = motor_dir;
  endtask

  // what: 0 = at_speed, 1 = settled idle, 2 = cmd_ready low, 3 = motor_speed 512
  task automatic run_until(input int what, input int budget);
    int  n;
    bit  hit;
    n = 0;
    hit = 0;
    while (!hit && n < budget) begin
      case (what)
        0: hit = (at_speed === 1'b1);
        1: hit = (busy === 1'b0 && at_speed === 1'b0);
        2: hit = (cmd_ready === 1'b0);
        default: hit = (motor_speed === CW'(512));
      endcase
      if (!hit) begin step(1'b0, 1'b0, 0); n++; end
    end
    chk("wait_bound", 32'(hit), 32'd1);
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, ".len"}, 32'(seq.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < seq.size(); i++)
      chk({tag, ".val"}, 32'(seq[i]), 32'(exp_seq[i]));
  endtask

  initial begin
    int n;
    dut_acc = 0;
    ready_low = 0;
    do_reset();
    do_reset();

`ifndef MOTOR_RAMP_WATCHDOG_EN
    // Ramp up from IDLE.
    seq.delete();
    step(1'b1, 1'b0, 1000);
    run_until(0, 60);
    exp_seq = '{256, 512, 768, 1000};
    chk_seq("ramp_up");
    chk("ramp_up.dir", 32'(motor_dir), 32'd0);

    // Reversal: brake, dead time, ramp the other way.
    seq.delete();
    step(1'b1, 1'b1, 600);
    run_until(2, 60);
    n = 0;
    while (cmd_ready === 1'b0 && n < 50) begin step(1'b0, 1'b0, 0); n++; end
    chk("dead_len", 32'(n), 32'(DEAD));
    run_until(0, 60);
    exp_seq = '{744, 488, 232, 0, 256, 512, 600};
    chk_seq("reverse");
    chk("reverse.dir", 32'(motor_dir), 32'd1);

    // Same-direction stop ramps down to IDLE.
    seq.delete();
    step(1'b1, 1'b1, 0);
    run_until(1, 60);
    exp_seq = '{344, 88, 0};
    chk_seq("stop");
    chk("stop.busy", 32'(busy), 32'd0);

    // Command held through DEAD is taken exactly once, on the first ready cycle.
    step(1'b1, 1'b0, 300);
    run_until(0, 60);
    step(1'b1, 1'b1, 200);
    run_until(2, 60);
    dut_acc = 0;
    ready_low = 0;
    n = 0;
    while (dut_acc == 0 && n < 50) begin step(1'b1, 1'b0, 500); n++; end
    chk("held.accepts", 32'(dut_acc), 32'd1);
    chk("held.stalled", 32'(ready_low), 32'(DEAD));
    run_until(0, 60);
    chk("held.speed", 32'(motor_speed), 32'd500);
    chk("held.dir", 32'(motor_dir), 32'd0);

    // Reset in the middle of a ramp.
    do_reset();
    step(1'b1, 1'b1, 1000);
    run_until(3, 60);
    do_reset();
    chk("midreset.speed", 32'(motor_speed), 32'd0);
    chk("midreset.busy", 32'(busy), 32'd0);
`else
    // Watchdog: reach HOLD, then stay silent.
    step(1'b1, 1'b0, 1000);
    repeat (9) step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1000);
    run_until(0, 60);
    chk("wdog.before", 32'(wdog_trip), 32'd0);
    run_until(1, 100);
    chk("wdog.trip", 32'(wdog_trip), 32'd1);
    chk("wdog.speed", 32'(motor_speed), 32'd0);
    step(1'b1, 1'b0, 100);
    chk("wdog.clear", 32'(wdog_trip), 32'd0);
`endif

    // Randomized command traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int s;
      s = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 1500));
      step(($urandom_range(0, 4) == 0), logic'($urandom_range(0, 1)), s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/motor_ramp_sequencer.md
MOTOR_RAMP_SEQUENCER -- requirements
Module: motor_ramp_sequencer

Interface
REQ-001 The block SHALL have parameter COUNTER_WIDTH, default 16, giving the speed word width; it matches the motor driver speed input.
REQ-002 The block SHALL have parameter TICK_CYCLES, default 50000, giving the clocks per ramp tick (1 ms at 50 MHz).
REQ-003 The block SHALL have parameter RAMP_STEP, default 256, giving the maximum speed change per tick.
REQ-004 The block SHALL have parameter DEAD_CYCLES, default 1000, giving the clocks at zero speed before a direction flip.
REQ-005 The block SHALL have parameter WDOG_TICKS, default 500, giving the ticks without a command before the watchdog stop (used only with the Configuration macro).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port cmd_valid, input, 1 bit: a command is presented.
REQ-009 The block SHALL have port cmd_ready, output, 1 bit: a command can be accepted.
REQ-010 The block SHALL have port cmd_dir, input, 1 bit: requested direction.
REQ-011 The block SHALL have port cmd_speed, input, COUNTER_WIDTH bits: requested target speed.
REQ-012 The block SHALL have port motor_dir, output, 1 bit: drives the motor driver dir input.
REQ-013 The block SHALL have port motor_speed, output, COUNTER_WIDTH bits: drives the motor driver speed input.
REQ-014 The block SHALL have port busy, output, 1 bit: high in states RAMP, BRAKE and DEAD.
REQ-015 The block SHALL have port at_speed, output, 1 bit: high in state HOLD.
REQ-016 The block SHALL have port wdog_trip, output, 1 bit: sticky watchdog flag.

Function
REQ-017 The block SHALL accept a command on a rising clk edge where cmd_valid and cmd_ready are both 1; it then latches tgt_dir and tgt_speed.
REQ-018 The block SHALL drive cmd_ready to 1 in every state except DEAD.
REQ-019 The block SHALL run a free-running prescaler that counts 0..TICK_CYCLES-1; the tick pulse is 1 for one clock when the count wraps to 0.
REQ-020 The block SHALL implement states IDLE, RAMP, HOLD, BRAKE and DEAD.
REQ-021 IDLE: motor_speed=0. On acceptance with cmd_speed>0, the block SHALL load motor_dir=cmd_dir on the same edge and go to RAMP; on acceptance with cmd_speed=0, it SHALL remain in IDLE.
REQ-022 RAMP: on each tick, the block SHALL move motor_speed toward tgt_speed by min(RAMP_STEP, |difference|), so it never overshoots.
REQ-023 RAMP: when motor_speed equals tgt_speed, the block SHALL go to HOLD if tgt_speed>0, else to IDLE.
REQ-024 HOLD: on acceptance of a command with the same direction and a different speed, the block SHALL go to RAMP.
REQ-025 The block SHALL go to BRAKE from RAMP or HOLD on acceptance of a command with cmd_dir != motor_dir and motor_speed>0.
REQ-026 BRAKE: on each tick, the block SHALL decrement motor_speed by min(RAMP_STEP, motor_speed); at 0 it SHALL go to DEAD.
REQ-027 DEAD: the block SHALL hold motor_speed=0 for exactly DEAD_CYCLES clocks, then set motor_dir=tgt_dir on the same edge and go to RAMP, or to IDLE if tgt_speed=0.
REQ-028 A new command accepted during BRAKE SHALL only update the target; BRAKE SHALL continue to zero regardless.
REQ-029 If a BRAKE command reverts to the original direction, the block SHALL still complete BRAKE and DEAD; the direction output simply remains unchanged.
REQ-030 motor_dir SHALL change only while motor_speed=0.
REQ-031 Speed arithmetic SHALL be unsigned COUNTER_WIDTH and SHALL never wrap below 0 or above tgt_speed.
REQ-032 When acceptance and a tick coincide, the step on that edge SHALL use the old target; the new target applies from the next tick.

Reset
REQ-033 rst=1 on a clk edge SHALL force state IDLE, motor_speed=0, motor_dir=0, tgt_speed=0, tgt_dir=0, prescaler=0, DEAD counter=0, watchdog=0 and wdog_trip=0.
REQ-034 Reset asserted mid-ramp SHALL zero motor_speed immediately, with no ramp-down; all outputs SHALL be at reset values in the cycle after the reset edge.

Configuration
REQ-035 With macro MOTOR_RAMP_WATCHDOG_EN defined, the block SHALL count ticks since the last accepted command; reaching WDOG_TICKS outside IDLE SHALL set tgt_speed=0, set wdog_trip=1 (sticky until a command is accepted or reset), and ramp down via RAMP.
REQ-036 Without MOTOR_RAMP_WATCHDOG_EN, the watchdog logic SHALL be absent and wdog_trip SHALL be tied to 0.

Verification
REQ-037 Scenario 1: TICK_CYCLES=4, RAMP_STEP=256; cmd dir=0, speed=1000 from IDLE -> motor_speed steps 256, 512, 768, 1000 on successive ticks; at_speed=1 after reaching 1000; motor_dir=0 throughout.
REQ-038 Scenario 2: in HOLD at 1000 dir=0, cmd dir=1, speed=600 -> BRAKE steps 744, 488, 232, 0; DEAD for DEAD_CYCLES clocks with cmd_ready=0; motor_dir=1; ramp 256, 512, 600; no cycle has motor_dir changed while motor_speed != 0.
REQ-039 Scenario 3: in HOLD at 1000, cmd same dir, speed 0 -> motor_speed ramps down to 0; state IDLE; busy=0.
REQ-040 Scenario 4: rst pulsed mid-ramp at 512 -> next cycle motor_speed=0, motor_dir=0, cmd_ready=1, busy=0.
REQ-041 Scenario 5 (MOTOR_RAMP_WATCHDOG_EN, WDOG_TICKS=3): HOLD at 1000, no commands -> after 3 ticks wdog_trip=1 and the speed ramps to 0; the next accepted command clears wdog_trip.
REQ-042 Scenario 6: cmd_valid held with cmd_ready=0 during DEAD -> the command is accepted on the first cycle cmd_ready=1, and no command is lost or double-accepted.
